// File: rtl/pc_seq_if.sv
// Command/status bundle between a PC-sequencer client and pc_seq_ctrl.
// Commands are level-sampled on every rising edge with no ready/backpressure; each sampled command takes effect on that edge.
interface pc_seq_if;
  logic       start;
  logic       hlt;
  logic       inc;
  logic       jmp;
  logic       call;
  logic       ret;
  logic [5:0] target;
  logic       ld;
  logic [5:0] Lvalue;
  logic       running;
  logic [3:0] depth;
  logic       stk_err;
  logic [1:0] dbg_state;

  modport master (
    output start, hlt, inc, jmp, call, ret, target,
    input  ld, Lvalue, running, depth, stk_err, dbg_state
  );

  modport slave (
    input  start, hlt, inc, jmp, call, ret, target,
    output ld, Lvalue, running, depth, stk_err, dbg_state
  );
endinterface

// File: rtl/pc_seq_ctrl.sv
// Next-address sequencer for the 6-bit PC register: inc/jmp/call/ret, return stack, run/halt FSM.
// Optional macro PC_WRAP_EN: inc at PC=63 wraps to 0 instead of halting.
module pc_seq_ctrl #(
  parameter logic [5:0]  RST_VEC = 6'd0,
  parameter int unsigned DEPTH   = 4
) (
  input logic      clk,
  input logic      rst,
  pc_seq_if.slave  bus
);

`ifdef PC_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] pc_sh_q, pc_sh_d;
  logic [5:0] lvalue_q, lvalue_d;
  logic       ld_q, ld_d;
  logic       running_q;
  logic       err_q, err_d;
  logic [3:0] depth_q, depth_d;
  logic       push;
  logic [5:0] stack_q [0:7];
  logic [5:0] pc_inc;
  logic [2:0] top_idx;
  logic       at_top, stk_full, stk_empty;

  // pc_inc is naturally mod 64; at 63 it is the wrap value 0.
  assign pc_inc    = pc_sh_q + 6'd1;
  assign at_top    = (pc_sh_q == 6'd63);
  assign stk_full  = (depth_q == 4'(DEPTH));
  assign stk_empty = (depth_q == 4'd0);
  assign top_idx   = depth_q[2:0] - 3'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_HALT: if (bus.start) state_d = ST_RUN;
      ST_RUN: begin
        if (bus.hlt)
          state_d = ST_HALT;
        else if (!bus.ret && !bus.call && !bus.jmp && bus.inc && at_top && !WRAP)
          state_d = ST_HALT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ld_d     = 1'b0;
    lvalue_d = lvalue_q;
    pc_sh_d  = pc_sh_q;
    depth_d  = depth_q;
    err_d    = err_q;
    push     = 1'b0;
    if (state_q == ST_RUN && !bus.hlt) begin
      if (bus.ret) begin
        if (stk_empty) begin
          err_d = 1'b1;
        end else begin
          pc_sh_d = stack_q[top_idx];
          depth_d = depth_q - 4'd1;
          ld_d    = 1'b1;
        end
      end else if (bus.call) begin
        if (stk_full) begin
          err_d = 1'b1;
        end else begin
          push    = 1'b1;
          pc_sh_d = bus.target;
          depth_d = depth_q + 4'd1;
          ld_d    = 1'b1;
        end
      end else if (bus.jmp) begin
        pc_sh_d = bus.target;
        ld_d    = 1'b1;
      end else if (bus.inc) begin
        if (!at_top || WRAP) begin
          pc_sh_d = pc_inc;
          ld_d    = 1'b1;
        end
      end
    end
    if (ld_d) lvalue_d = pc_sh_d;
  end

  // ld is held high in reset so the PC register keeps capturing RST_VEC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_sh_q   <= RST_VEC;
      lvalue_q  <= RST_VEC;
      ld_q      <= 1'b1;
      running_q <= 1'b0;
      depth_q   <= 4'd0;
      err_q     <= 1'b0;
    end else begin
      pc_sh_q   <= pc_sh_d;
      lvalue_q  <= lvalue_d;
      ld_q      <= ld_d;
      running_q <= (state_d == ST_RUN);
      depth_q   <= depth_d;
      err_q     <= err_d;
    end
  end

  // Entries are never cleared; occupancy alone defines the live stack.
  always_ff @(posedge clk) begin
    if (push) stack_q[depth_q[2:0]] <= pc_inc;
  end

  assign bus.ld        = ld_q;
  assign bus.Lvalue    = lvalue_q;
  assign bus.running   = running_q;
  assign bus.depth     = depth_q;
  assign bus.stk_err   = err_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Self-checking bench for pc_seq_ctrl: directed test-plan steps plus randomized commands
// against a queue-based behavioural model.
module tb_pc_seq_ctrl;
  localparam logic [5:0] RV  = 6'd5;
  localparam int         DEP = 4;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  bit   chk_en = 1'b0;

  pc_seq_if bus();

  pc_seq_ctrl #(.RST_VEC(RV), .DEPTH(DEP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 run, 2 halt
  int         m_mode;
  int         m_pc;
  int         m_lv;
  bit         m_ld;
  bit         m_loaded;
  bit         m_err;
  bit         m_run;
  int         m_stk[$];
  logic [5:0] exp_q[$];

  task automatic model_reset();
    m_mode = 0; m_pc = RV; m_lv = RV; m_ld = 1'b1; m_loaded = 1'b0;
    m_err = 1'b0; m_run = 1'b0;
    m_stk.delete();
    exp_q.delete();
  endtask

  task automatic model_load(int v);
    m_pc = v; m_lv = v; m_ld = 1'b1; m_loaded = 1'b1;
    exp_q.push_back(6'(v));
  endtask

  task automatic model_step();
    m_ld = 1'b0;
    m_loaded = 1'b0;
    if (m_mode != 1) begin
      if (bus.start) m_mode = 1;
    end else if (bus.hlt) begin
      m_mode = 2;
    end else if (bus.ret) begin
      if (m_stk.size() == 0) m_err = 1'b1;
      else model_load(m_stk.pop_back());
    end else if (bus.call) begin
      if (m_stk.size() == DEP) m_err = 1'b1;
      else begin
        m_stk.push_back((m_pc + 1) % 64);
        model_load(int'(bus.target));
      end
    end else if (bus.jmp) begin
      model_load(int'(bus.target));
    end else if (bus.inc) begin
      if (m_pc == 63) begin
`ifdef PC_WRAP_EN
        model_load(0);
`else
        m_mode = 2;
`endif
      end else begin
        model_load(m_pc + 1);
      end
    end
    m_run = (m_mode == 1);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
  end

  // ---------------- checking ----------------
  task automatic chk(string name, int got, int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin : compare
    int want_lv;
    if (chk_en) begin
      want_lv = m_lv;
      if (m_loaded) want_lv = (exp_q.size() != 0) ? int'(exp_q.pop_front()) : -1;
      chk("ld",      int'(bus.ld),        int'(m_ld));
      chk("Lvalue",  int'(bus.Lvalue),    want_lv);
      chk("running", int'(bus.running),   int'(m_run));
      chk("depth",   int'(bus.depth),     m_stk.size());
      chk("stk_err", int'(bus.stk_err),   int'(m_err));
      chk("state",   int'(bus.dbg_state), m_mode);
    end
  end

  // ---------------- driver ----------------
  task automatic drive(bit s, bit h, bit i, bit j, bit c, bit r, logic [5:0] t);
    bus.start = s; bus.hlt = h; bus.inc = i; bus.jmp = j;
    bus.call = c; bus.ret = r; bus.target = t;
    @(negedge clk);
  endtask

  task automatic async_reset_pulse(string tag);
    #2 rst = 1'b1;
    #1;
    chk({tag, "_ld"},      int'(bus.ld),      1);
    chk({tag, "_Lvalue"},  int'(bus.Lvalue),  int'(RV));
    chk({tag, "_depth"},   int'(bus.depth),   0);
    chk({tag, "_running"}, int'(bus.running), 0);
    chk({tag, "_stk_err"}, int'(bus.stk_err), 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int pops[4];
    pops = '{23, 22, 21, 12};
    rst = 1'b0;
    bus.start = 1'b0; bus.hlt = 1'b0; bus.inc = 1'b0; bus.jmp = 1'b0;
    bus.call = 1'b0; bus.ret = 1'b0; bus.target = 6'd0;
    #2 rst = 1'b1;
    #1 chk_en = 1'b1;

    repeat (3) begin
      @(negedge clk);
      chk("rst_hold_ld", int'(bus.ld), 1);
      chk("rst_hold_Lvalue", int'(bus.Lvalue), 5);
    end
    rst = 1'b0;

    drive(0, 0, 0, 0, 0, 0, 6'd0);
    chk("release_ld", int'(bus.ld), 0);
    drive(0, 0, 1, 0, 0, 0, 6'd0);
    chk("idle_inc_ld", int'(bus.ld), 0);
    chk("idle_inc_Lvalue", int'(bus.Lvalue), 5);
    drive(1, 0, 0, 0, 0, 0, 6'd0);
    chk("start_running", int'(bus.running), 1);

    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 1, 0, 0, 0, 6'd0);
      chk("seq_inc_ld", int'(bus.ld), 1);
      chk("seq_inc_Lvalue", int'(bus.Lvalue), 6 + k);
    end
    drive(0, 0, 0, 1, 0, 0, 6'd40);
    chk("jmp40_Lvalue", int'(bus.Lvalue), 40);

    drive(0, 0, 0, 1, 0, 0, 6'd9);
    drive(0, 0, 1, 0, 0, 0, 6'd0);
    chk("pc10_Lvalue", int'(bus.Lvalue), 10);
    drive(0, 0, 0, 0, 1, 0, 6'd30);
    chk("call30_Lvalue", int'(bus.Lvalue), 30);
    chk("call30_depth", int'(bus.depth), 1);
    drive(0, 0, 0, 0, 0, 1, 6'd0);
    chk("ret11_Lvalue", int'(bus.Lvalue), 11);
    chk("ret11_depth", int'(bus.depth), 0);

    for (int k = 0; k < 5; k++) drive(0, 0, 0, 0, 1, 0, 6'(20 + k));
    chk("overflow_ld", int'(bus.ld), 0);
    chk("overflow_depth", int'(bus.depth), 4);
    chk("overflow_err", int'(bus.stk_err), 1);
    chk("overflow_Lvalue", int'(bus.Lvalue), 23);
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 0, 0, 1, 6'd0);
      chk("pop_order", int'(bus.Lvalue), pops[k]);
    end
    drive(0, 0, 0, 0, 0, 1, 6'd0);
    chk("underflow_ld", int'(bus.ld), 0);
    chk("underflow_err", int'(bus.stk_err), 1);

    drive(0, 0, 0, 1, 0, 0, 6'd50);
    drive(0, 0, 0, 0, 1, 0, 6'd7);
    drive(0, 0, 1, 0, 1, 1, 6'd33);
    chk("prio_ret_Lvalue", int'(bus.Lvalue), 51);
    chk("prio_ret_depth", int'(bus.depth), 0);
    drive(0, 1, 0, 1, 0, 0, 6'd12);
    chk("prio_hlt_ld", int'(bus.ld), 0);
    chk("prio_hlt_running", int'(bus.running), 0);

    drive(1, 0, 0, 0, 0, 0, 6'd0);
    drive(0, 0, 0, 1, 0, 0, 6'd63);
    chk("jmp63_Lvalue", int'(bus.Lvalue), 63);
    drive(0, 0, 1, 0, 0, 0, 6'd0);
`ifdef PC_WRAP_EN
    chk("wrap_ld", int'(bus.ld), 1);
    chk("wrap_Lvalue", int'(bus.Lvalue), 0);
    chk("wrap_running", int'(bus.running), 1);
`else
    chk("top_ld", int'(bus.ld), 0);
    chk("top_running", int'(bus.running), 0);
`endif

    drive(1, 0, 0, 0, 0, 0, 6'd0);
    drive(0, 0, 0, 0, 1, 0, 6'd44);
    async_reset_pulse("async");

    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 79) == 0) begin
        async_reset_pulse("rand_async");
      end else begin
        drive($urandom_range(0, 7) == 0, $urandom_range(0, 29) == 0,
              $urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0,
              $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
              ($urandom_range(0, 3) == 0) ? 6'd63 : 6'($urandom_range(0, 63)));
      end
    end

    drive(0, 0, 0, 0, 0, 0, 6'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
